pulse_synth: RTL

PULSE_SYNTH -- requirements
Module: pulse_synth

---
 rtl/package_settings.sv | 8 +
 rtl/pulse_synth_if.sv | 28 ++
 rtl/pulse_synth.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/package_settings.sv
// ----------------------------------------------------------------------------
// package_settings
// Shared front-end settings for the ADC datapath blocks.
//   SIZE_ADC_DATA : width of ADC samples in bits.
// ----------------------------------------------------------------------------
package package_settings;
    localparam int SIZE_ADC_DATA = 12;
endpackage

// File: rtl/pulse_synth_if.sv
// ----------------------------------------------------------------------------
// pulse_synth_if
// Trigger handshake and synthesized sample stream of pulse_synth.
//   trig_valid   : pulse request (master -> slave)
//   trig_amp     : requested amplitude in ADC counts, unsigned (master -> slave)
//   trig_ready   : request may be accepted this cycle (slave -> master)
//   sample_out   : synthesized ADC sample, unsigned (slave -> master)
//   sample_valid : sample_out updated this cycle (slave -> master)
// ----------------------------------------------------------------------------
interface pulse_synth_if #(
    parameter int SIZE_ADC_DATA = package_settings::SIZE_ADC_DATA
);
    logic                     trig_valid;
    logic [SIZE_ADC_DATA-1:0] trig_amp;
    logic                     trig_ready;
    logic [SIZE_ADC_DATA-1:0] sample_out;
    logic                     sample_valid;

    modport master (
        output trig_valid, trig_amp,
        input  trig_ready, sample_out, sample_valid
    );

    modport slave (
        input  trig_valid, trig_amp,
        output trig_ready, sample_out, sample_valid
    );
endinterface

// File: rtl/pulse_synth.sv
// ----------------------------------------------------------------------------
// pulse_synth
// Synthesizes detector-like pulses on top of a constant baseline: a linear
// rise of 2^RISE_LOG2 steps followed by an exponential decay, all held in an
// unsigned fixed-point accumulator with FRAC fractional bits.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   enable     : sample strobe; all state freezes while low
//   bus        : pulse_synth_if.slave (trigger handshake + sample stream)
//   busy       : registered, high while a pulse is in progress
//   pileup_cnt : triggers accepted during decay, saturating at 255
// ----------------------------------------------------------------------------
module pulse_synth #(
    parameter int SIZE_ADC_DATA = package_settings::SIZE_ADC_DATA,
    parameter int FRAC          = 8,
    parameter int DECAY_SHIFT   = 6,
    parameter int RISE_LOG2     = 2,
    parameter int BASELINE      = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    pulse_synth_if.slave        bus,
    output logic                busy,
    output logic [7:0]          pileup_cnt
);

    localparam int ACC_W = SIZE_ADC_DATA + FRAC + 1;
    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = RISE_LOG2 + 1;
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'((1 << RISE_LOG2) - 1);
    localparam logic [SUM_W-1:0] OUT_MAX   = SUM_W'((64'd1 << SIZE_ADC_DATA) - 1);

    typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

    state_t                   state_q;
    logic [ACC_W-1:0]         acc_q;
    logic [ACC_W-1:0]         step_q;
    logic [CNT_W-1:0]         rise_cnt_q;
    logic [7:0]               pileup_q;
    logic [SIZE_ADC_DATA-1:0] sample_q;
    logic                     sample_valid_q;
    logic                     busy_q;

    logic [ACC_W-1:0]         step_d;
    logic [ACC_W-1:0]         acc_decay_d;
    logic [ACC_W-1:0]         acc_rise_d;
    logic                     accept;

    // Saturating add: the accumulator pins at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    // Integer part of the accumulator plus baseline, clamped to full scale.
    function automatic logic [SIZE_ADC_DATA-1:0] to_sample(input logic [ACC_W-1:0] a);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a >> FRAC) + SUM_W'(BASELINE);
        return (s > OUT_MAX) ? '1 : s[SIZE_ADC_DATA-1:0];
    endfunction

    // Ready is withheld during reset and for the whole rise phase.
    assign bus.trig_ready = enable & reset & (state_q != RISE);
    assign accept         = bus.trig_ready & bus.trig_valid;

    // Amplitude spread evenly over the rise steps, in accumulator units.
    assign step_d      = (ACC_W'(bus.trig_amp) << FRAC) >> RISE_LOG2;
    // Decay cannot underflow: acc>>DECAY_SHIFT never exceeds acc.
    assign acc_decay_d = acc_q - (acc_q >> DECAY_SHIFT);
    assign acc_rise_d  = sat_add(acc_decay_d, step_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            step_q         <= '0;
            rise_cnt_q     <= '0;
            pileup_q       <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else if (enable) begin
            // Output reflects the accumulator as it was before this edge.
            sample_q       <= to_sample(acc_q);
            sample_valid_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        step_q     <= step_d;
                        rise_cnt_q <= '0;
                        state_q    <= RISE;
                        busy_q     <= 1'b1;
                    end else begin
                        busy_q     <= 1'b0;
                    end
                end
                RISE: begin
                    acc_q      <= acc_rise_d;
                    rise_cnt_q <= rise_cnt_q + CNT_W'(1);
                    busy_q     <= 1'b1;
                    if (rise_cnt_q == RISE_LAST) begin
                        state_q <= DECAY;
                    end
                end
                DECAY: begin
                    if (accept) begin
                        // Pile-up: new rise stacks on the residual tail.
                        step_q     <= step_d;
                        rise_cnt_q <= '0;
                        state_q    <= RISE;
                        busy_q     <= 1'b1;
                        if (pileup_q != 8'hFF) begin
                            pileup_q <= pileup_q + 8'd1;
                        end
                    end else if ((acc_q >> FRAC) == '0) begin
                        // Sub-LSB residue is dropped so the baseline is exact.
                        acc_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q  <= acc_decay_d;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end else begin
            sample_valid_q <= 1'b0;
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign busy             = busy_q;
    assign pileup_cnt       = pileup_q;

endmodule
